texture_block_fetch: RTL and testbench



---
 rtl/texture_block_fetch_pkg.sv | 57 +++++
 rtl/texture_block_fetch_if.sv | 56 +++++
 rtl/texture_block_fetch_addr.sv | 50 +++++
 rtl/texture_block_fetch.sv | 175 +++++++++++++++++
 tb/tb_texture_block_fetch.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/texture_block_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : texture_pkg
// Purpose  : Shared types and constants for the texture block fetch unit:
//            texel format enum, FSM state enum, words-per-block constants,
//            block width constants and helper functions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package texture_pkg;

  typedef enum logic [1:0] {
    FMT_RGB565   = 2'b00,
    FMT_RGBA8888 = 2'b01,
    FMT_R8       = 2'b10,
    FMT_RSVD     = 2'b11
  } tex_fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_REQ  = 3'd2,
    ST_FILL = 3'd3,
    ST_OUT  = 3'd4
  } fetch_state_e;

  // 16-bit SDRAM words needed for one 4x4 block
  localparam int WPB_RGB565   = 16;
  localparam int WPB_RGBA8888 = 32;
  localparam int WPB_R8       = 8;

  // Meaningful bits of a block, per format
  localparam int BLOCK_W_R8       = 128;
  localparam int BLOCK_W_RGB565   = 256;
  localparam int BLOCK_W_RGBA8888 = 512;

  function automatic logic [5:0] words_per_block(input tex_fmt_e fmt);
    case (fmt)
      FMT_RGB565:   return 6'(WPB_RGB565);
      FMT_RGBA8888: return 6'(WPB_RGBA8888);
      FMT_R8:       return 6'(WPB_R8);
      default:      return 6'd0;
    endcase
  endfunction

  // log2(words_per_block) so block offsets are formed by a shift
  function automatic logic [2:0] wpb_shift(input tex_fmt_e fmt);
    case (fmt)
      FMT_RGB565:   return 3'd4;
      FMT_RGBA8888: return 3'd5;
      FMT_R8:       return 3'd3;
      default:      return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/texture_block_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : texture_block_fetch_if
// Purpose  : Bundles the request, SDRAM burst and block output handshakes.
//            master : environment side (requester, memory, decoder)
//            slave  : texture_block_fetch side
// Ports    : req_*   texel request (valid/ready)
//            mem_*   burst read request and read beats
//            out_*, block_data, texel_idx : block output (valid/ready)
// Revision : 1.0 - initial release
// ============================================================================
interface texture_block_fetch_if #(
  parameter int ADDR_W = 24,
  parameter int UV_W   = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [UV_W-1:0]   req_u;
  logic [UV_W-1:0]   req_v;
  logic [ADDR_W-1:0] req_base;
  logic [1:0]        req_fmt;
  logic [3:0]        req_wlog2;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [5:0]        mem_len;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [511:0]      block_data;
  logic [3:0]        texel_idx;
  logic [1:0]        out_fmt;

  modport master (
    output req_valid, req_u, req_v, req_base, req_fmt, req_wlog2,
    input  req_ready,
    input  mem_req, mem_addr, mem_len,
    output mem_ack, mem_rvalid, mem_rdata,
    input  out_valid, block_data, texel_idx, out_fmt,
    output out_ready
  );

  modport slave (
    input  req_valid, req_u, req_v, req_base, req_fmt, req_wlog2,
    output req_ready,
    output mem_req, mem_addr, mem_len,
    input  mem_ack, mem_rvalid, mem_rdata,
    output out_valid, block_data, texel_idx, out_fmt,
    input  out_ready
  );

endinterface
`default_nettype wire

// File: rtl/texture_block_fetch_addr.sv
`default_nettype none
// ============================================================================
// Module   : texture_block_addr
// Purpose  : Combinational 4x4 block address, burst length and in-block
//            texel index for a latched texel request.
// Ports    : u, v      texel coordinates
//            base      texture base word address
//            fmt       texel format
//            wlog2     log2 texture width (values below 2 act as 2)
//            addr      burst start word address (wraps modulo 2^ADDR_W)
//            len       burst length in 16-bit words
//            idx       texel index within the block {v[1:0], u[1:0]}
// Revision : 1.0 - initial release
// ============================================================================
module texture_block_addr
  import texture_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int UV_W   = 10
) (
  input  logic [UV_W-1:0]   u,
  input  logic [UV_W-1:0]   v,
  input  logic [ADDR_W-1:0] base,
  input  tex_fmt_e          fmt,
  input  logic [3:0]        wlog2,
  output logic [ADDR_W-1:0] addr,
  output logic [5:0]        len,
  output logic [3:0]        idx
);

  logic [UV_W-3:0]   bx;
  logic [UV_W-3:0]   by;
  logic [3:0]        wl_eff;
  logic [3:0]        row_shift;
  logic [ADDR_W-1:0] blk;

  always_comb begin
    bx        = u[UV_W-1:2];
    by        = v[UV_W-1:2];
    wl_eff    = (wlog2 < 4'd2) ? 4'd2 : wlog2;
    // blocks per row = width/4, so a block row is (wlog2-2) bits wide
    row_shift = wl_eff - 4'd2;
    blk       = (ADDR_W'(by) << row_shift) + ADDR_W'(bx);
    len       = words_per_block(fmt);
    addr      = base + (blk << wpb_shift(fmt));
    idx       = {v[1:0], u[1:0]};
  end

endmodule
`default_nettype wire

// File: rtl/texture_block_fetch.sv
`default_nettype none
// ============================================================================
// Module   : texture_block_fetch
// Purpose  : Accepts a texel request, computes the address of its 4x4 block,
//            burst-reads the block from SDRAM as 16-bit words and presents the
//            packed 512-bit block, texel index and format downstream.
// Ports    : clk    system clock
//            rst_n  asynchronous active-low reset
//            bus    texture_block_fetch_if.slave (request, memory, output)
// Options  : TEX_BLOCK_REUSE_EN - single-entry tag; a request hitting the
//            last completed block is served from the buffer without a fetch.
// Revision : 1.0 - initial release
// ============================================================================
module texture_block_fetch
  import texture_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int UV_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  texture_block_fetch_if.slave  bus
);

  fetch_state_e      state;
  fetch_state_e      state_nx;

  logic              ready_q;
  logic [UV_W-1:0]   u_q;
  logic [UV_W-1:0]   v_q;
  logic [ADDR_W-1:0] base_q;
  tex_fmt_e          fmt_q;
  logic [3:0]        wlog2_q;

  logic [ADDR_W-1:0] addr_q;
  logic [5:0]        len_q;
  logic [3:0]        idx_q;
  logic [BLOCK_W_RGBA8888-1:0] buf_q;
  logic [4:0]        cnt_q;

  logic [ADDR_W-1:0] calc_addr;
  logic [5:0]        calc_len;
  logic [3:0]        calc_idx;

  logic              accept;
  logic              fill_last;
  logic              tag_hit;

  texture_block_addr #(
    .ADDR_W (ADDR_W),
    .UV_W   (UV_W)
  ) u_addr (
    .u     (u_q),
    .v     (v_q),
    .base  (base_q),
    .fmt   (fmt_q),
    .wlog2 (wlog2_q),
    .addr  (calc_addr),
    .len   (calc_len),
    .idx   (calc_idx)
  );

  assign accept    = bus.req_valid && ready_q;
  assign fill_last = bus.mem_rvalid && ({1'b0, cnt_q} == (len_q - 6'd1));

`ifdef TEX_BLOCK_REUSE_EN
  logic              tag_valid_q;
  logic [ADDR_W-1:0] tag_base_q;
  tex_fmt_e          tag_fmt_q;
  logic [3:0]        tag_wlog2_q;
  logic [UV_W-3:0]   tag_bx_q;
  logic [UV_W-3:0]   tag_by_q;

  assign tag_hit = tag_valid_q
                && (tag_base_q  == base_q)
                && (tag_fmt_q   == fmt_q)
                && (tag_wlog2_q == wlog2_q)
                && (tag_bx_q    == u_q[UV_W-1:2])
                && (tag_by_q    == v_q[UV_W-1:2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q <= 1'b0;
      tag_base_q  <= '0;
      tag_fmt_q   <= FMT_RGB565;
      tag_wlog2_q <= '0;
      tag_bx_q    <= '0;
      tag_by_q    <= '0;
    end else if (state == ST_CALC && state_nx == ST_REQ) begin
      // buffer is about to be overwritten; its old contents no longer valid
      tag_valid_q <= 1'b0;
    end else if (state == ST_FILL && fill_last) begin
      tag_valid_q <= 1'b1;
      tag_base_q  <= base_q;
      tag_fmt_q   <= fmt_q;
      tag_wlog2_q <= wlog2_q;
      tag_bx_q    <= u_q[UV_W-1:2];
      tag_by_q    <= v_q[UV_W-1:2];
    end
  end
`else
  assign tag_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_CALC;
      ST_CALC: state_nx = (fmt_q == FMT_RSVD || tag_hit) ? ST_OUT : ST_REQ;
      ST_REQ:  if (bus.mem_ack) state_nx = ST_FILL;
      ST_FILL: if (fill_last) state_nx = ST_OUT;
      ST_OUT:  if (bus.out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
      base_q  <= '0;
      fmt_q   <= FMT_RGB565;
      wlog2_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      // registered so req_ready is low during and right after reset
      ready_q <= (state_nx == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            u_q     <= bus.req_u;
            v_q     <= bus.req_v;
            base_q  <= bus.req_base;
            fmt_q   <= tex_fmt_e'(bus.req_fmt);
            wlog2_q <= bus.req_wlog2;
          end
        end
        ST_CALC: begin
          addr_q <= calc_addr;
          len_q  <= calc_len;
          idx_q  <= calc_idx;
          if (!tag_hit) begin
            buf_q <= '0;
            cnt_q <= '0;
          end
        end
        ST_FILL: begin
          if (bus.mem_rvalid) begin
            buf_q[{cnt_q, 4'd0} +: 16] <= bus.mem_rdata;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.mem_req    = (state == ST_REQ);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_len    = len_q;
  assign bus.out_valid  = (state == ST_OUT);
  assign bus.block_data = buf_q;
  assign bus.texel_idx  = idx_q;
  assign bus.out_fmt    = fmt_q;

endmodule
`default_nettype wire

// File: tb/tb_texture_block_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_texture_block_fetch
// Purpose  : Directed self-checking bench for texture_block_fetch. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Options  : TEX_BLOCK_REUSE_EN enables the block reuse scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_texture_block_fetch;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [15:0]  beats [32];
  logic [511:0] exp_blk;

  texture_block_fetch_if #(.ADDR_W(24), .UV_W(10)) bus ();

  texture_block_fetch #(.ADDR_W(24), .UV_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic send_req(input logic [9:0] u, input logic [9:0] v,
                          input logic [23:0] base, input logic [1:0] fmt,
                          input logic [3:0] wl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    bus.req_valid = 1'b1; bus.req_u = u; bus.req_v = v;
    bus.req_base = base; bus.req_fmt = fmt; bus.req_wlog2 = wl;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_req === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic serve_burst(input int n, output bit ok);
    wait_mem_req(ok);
    if (!ok) return;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = beats[i];
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic finish_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (bus.block_data !== 512'd0 || bus.mem_addr !== 24'd0 || bus.mem_len !== 6'd0 || bus.texel_idx !== 4'd0 || bus.out_fmt !== 2'd0) begin
      failures++; $display("FAIL rst_outputs addr=%h len=%0d idx=%h fmt=%b exp all zero", bus.mem_addr, bus.mem_len, bus.texel_idx, bus.out_fmt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_rgb565();
    bit ok;
    exp_blk = '0;
    for (int i = 0; i < 16; i++) beats[i] = 16'h1000 + 16'(i);
    beats[0] = 16'hF800; beats[1] = 16'h07E0;
    for (int i = 0; i < 16; i++) exp_blk[i*16 +: 16] = beats[i];
    send_req(10'd5, 10'd9, 24'h001000, 2'b00, 4'd6, ok);
    wait_mem_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rgb_mem_req got=timeout exp=mem_req"); return; end
    checks++; if (bus.mem_addr !== 24'h001210) begin failures++; $display("FAIL rgb_addr got=%h exp=001210", bus.mem_addr); end
    checks++; if (bus.mem_len !== 6'd16) begin failures++; $display("FAIL rgb_len got=%0d exp=16", bus.mem_len); end
    serve_burst(16, ok);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rgb_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.block_data[31:0] !== 32'h07E0F800) begin failures++; $display("FAIL rgb_beats01 got=%h exp=07e0f800", bus.block_data[31:0]); end
    checks++; if (bus.block_data !== exp_blk) begin failures++; $display("FAIL rgb_block got=%h exp=%h", bus.block_data[255:0], exp_blk[255:0]); end
    checks++; if (bus.texel_idx !== 4'h5 || bus.out_fmt !== 2'b00) begin failures++; $display("FAIL rgb_idx_fmt got=%h/%b exp=5/00", bus.texel_idx, bus.out_fmt); end
    finish_out();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rgb_out_drop got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_rgba_backpressure();
    bit ok;
    bit stable;
    exp_blk = '0;
    for (int i = 0; i < 32; i++) begin beats[i] = 16'(i); exp_blk[i*16 +: 16] = 16'(i); end
    send_req(10'd0, 10'd0, 24'h000000, 2'b01, 4'd5, ok);
    wait_mem_req(ok);
    checks++; if (!ok || bus.mem_len !== 6'd32 || bus.mem_addr !== 24'd0) begin
      failures++; $display("FAIL rgba_req got=ok%0d len=%0d addr=%h exp=len32 addr0", ok, bus.mem_len, bus.mem_addr);
    end
    serve_burst(32, ok);
    checks++; if (bus.block_data[511:496] !== 16'h001F) begin failures++; $display("FAIL rgba_top_word got=%h exp=001f", bus.block_data[511:496]); end
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.block_data !== exp_blk || bus.texel_idx !== 4'h0 || bus.out_fmt !== 2'b01) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL rgba_hold got=unstable exp=stable valid=%b", bus.out_valid); end
    finish_out();
  endtask

  task automatic test_r8_delayed_ack();
    bit ok;
    bit held;
    exp_blk = '0;
    for (int i = 0; i < 8; i++) begin beats[i] = 16'h00A0 + 16'(i); exp_blk[i*16 +: 16] = beats[i]; end
    send_req(10'd13, 10'd2, 24'h002000, 2'b10, 4'd4, ok);
    wait_mem_req(ok);
    checks++; if (!ok || bus.mem_addr !== 24'h002018 || bus.mem_len !== 6'd8) begin
      failures++; $display("FAIL r8_req got=addr %h len %0d exp=002018 len 8", bus.mem_addr, bus.mem_len);
    end
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 24'h002018 || bus.mem_len !== 6'd8) held = 1'b0;
    end
    checks++; if (!held) begin failures++; $display("FAIL r8_req_hold got=dropped exp=held mem_req=%b", bus.mem_req); end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL r8_req_drop got=%b exp=0", bus.mem_req); end
    for (int i = 0; i < 8; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = beats[i];
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL r8_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.block_data[511:128] !== 384'd0) begin failures++; $display("FAIL r8_upper_zero got=nonzero exp=0"); end
    checks++; if (bus.block_data[127:0] !== exp_blk[127:0]) begin failures++; $display("FAIL r8_block got=%h exp=%h", bus.block_data[127:0], exp_blk[127:0]); end
    checks++; if (bus.out_fmt !== 2'b10 || bus.texel_idx !== 4'h9) begin failures++; $display("FAIL r8_fmt_idx got=%b/%h exp=10/9", bus.out_fmt, bus.texel_idx); end
    finish_out();
  endtask

  task automatic test_reserved();
    bit ok;
    send_req(10'd7, 10'd2, 24'h000300, 2'b11, 4'd4, ok);
    checks++; if (!ok || bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL rsvd_calc got=valid %b req %b exp=0 0", bus.out_valid, bus.mem_req);
    end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL rsvd_out got=valid %b req %b exp=1 0", bus.out_valid, bus.mem_req);
    end
    checks++; if (bus.block_data !== 512'd0 || bus.out_fmt !== 2'b11 || bus.texel_idx !== 4'hB) begin
      failures++; $display("FAIL rsvd_data got=fmt %b idx %h exp=zero block fmt 11 idx b", bus.out_fmt, bus.texel_idx);
    end
    finish_out();
  endtask

  task automatic test_boundary();
    bit ok;
    for (int i = 0; i < 16; i++) beats[i] = 16'h0700 + 16'(i);
    // wlog2 0 behaves as 2: bx=1 by=1 -> blk 2 -> +32 words
    send_req(10'd4, 10'd4, 24'h000100, 2'b00, 4'd0, ok);
    wait_mem_req(ok);
    checks++; if (!ok || bus.mem_addr !== 24'h000120) begin failures++; $display("FAIL wlog2_clamp got=%h exp=000120", bus.mem_addr); end
    serve_burst(16, ok);
    finish_out();
    // address wraps: 0xFFFFFC + 1 block * 8 words
    send_req(10'd4, 10'd0, 24'hFFFFFC, 2'b10, 4'd3, ok);
    wait_mem_req(ok);
    checks++; if (!ok || bus.mem_addr !== 24'h000004) begin failures++; $display("FAIL addr_wrap got=%h exp=000004", bus.mem_addr); end
    serve_burst(8, ok);
    finish_out();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit quiet;
    send_req(10'd0, 10'd0, 24'h000000, 2'b00, 4'd2, ok);
    wait_mem_req(ok);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hBEE0 + 16'(i);
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hBEE5;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 6; i < 16; i++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hBEE0 + 16'(i);
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) quiet = 1'b0;
    end
    bus.mem_rvalid = 1'b0;
    checks++; if (!quiet) begin failures++; $display("FAIL midrst_quiet got=activity exp=idle"); end
    checks++; if (bus.req_ready !== 1'b1 || bus.block_data !== 512'd0) begin
      failures++; $display("FAIL midrst_idle got=ready %b exp=ready 1 zero block", bus.req_ready);
    end
    for (int i = 0; i < 8; i++) beats[i] = 16'h5A00 + 16'(i);
    send_req(10'd0, 10'd0, 24'h000040, 2'b10, 4'd2, ok);
    wait_mem_req(ok);
    checks++; if (!ok || bus.mem_addr !== 24'h000040) begin failures++; $display("FAIL midrst_next_addr got=%h exp=000040", bus.mem_addr); end
    serve_burst(8, ok);
    checks++; if (bus.out_valid !== 1'b1 || bus.block_data[127:0] !== 128'h5A075A065A055A045A035A025A015A00) begin
      failures++; $display("FAIL midrst_next_block got=%h exp=5a07..5a00", bus.block_data[127:0]);
    end
    finish_out();
  endtask

`ifdef TEX_BLOCK_REUSE_EN
  task automatic test_reuse();
    bit ok;
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin beats[i] = 16'h3000 + 16'(i); exp_blk[i*16 +: 16] = beats[i]; end
    send_req(10'd5, 10'd9, 24'h001000, 2'b00, 4'd6, ok);
    serve_burst(16, ok);
    finish_out();
    send_req(10'd6, 10'd9, 24'h001000, 2'b00, 4'd6, ok);
    checks++; if (!ok || bus.mem_req !== 1'b0) begin failures++; $display("FAIL reuse_calc got=req %b exp=0", bus.mem_req); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL reuse_out got=valid %b req %b exp=1 0", bus.out_valid, bus.mem_req);
    end
    checks++; if (bus.texel_idx !== 4'h6 || bus.block_data !== exp_blk) begin
      failures++; $display("FAIL reuse_data got=idx %h exp=idx 6 same block", bus.texel_idx);
    end
    finish_out();
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_u = '0; bus.req_v = '0; bus.req_base = '0;
    bus.req_fmt = '0; bus.req_wlog2 = '0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_rgb565();
    test_rgba_backpressure();
    test_r8_delayed_ack();
    test_reserved();
    test_boundary();
    test_reset_mid_burst();
`ifdef TEX_BLOCK_REUSE_EN
    test_reuse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
